sub_saturate_pipe: RTL
======================

SUB_SATURATE_PIPE -- requirements
Module: sub_saturate_pipe

Interface
REQ-001 Parameter N, default 7, is the signed two's-complement width of the operands and the result.
REQ-002 Parameter CNT_W, default 16, is the width of the saturation event counter.
REQ-003 Port i_clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 Port i_rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 Port i_valid, input, 1 bit: the upstream operand pair is valid.
REQ-006 Port o_ready, output, 1 bit: the block accepts an operand pair this cycle.
REQ-007 Port i_a, input, N bits signed: minuend (e.g. a posterior LLR).
REQ-008 Port i_b, input, N bits signed: subtrahend (e.g. an old check-to-variable message).
REQ-009 Port o_valid, output, 1 bit: o_c and o_sat are valid.
REQ-010 Port i_ready, input, 1 bit: downstream accepts the result this cycle.
REQ-011 Port o_c, output, N bits signed: saturated result of i_a - i_b.
REQ-012 Port o_sat, output, 1 bit: o_c was clamped.
REQ-013 Port i_clr_cnt, input, 1 bit: synchronous clear of o_sat_cnt.
REQ-014 Port o_sat_cnt, output, CNT_W bits unsigned: count of saturated results delivered.

Function
REQ-015 The input handshake SHALL complete when i_valid && o_ready; the output handshake SHALL complete when o_valid && i_ready.
REQ-016 The datapath SHALL have two register stages: S1 holds the (N+1)-bit sign-extended difference; S2 holds the clamped o_c and o_sat.
REQ-017 S2 SHALL load when !o_valid || i_ready; S1 SHALL advance when S1 is empty or S2 loads; o_ready SHALL equal that S1 advance condition, combinationally.
REQ-018 With i_ready held high, the result for a pair accepted in cycle t SHALL appear with o_valid=1 in cycle t+2, at a throughput of one pair per cycle.
REQ-019 While o_valid=1 && i_ready=0, o_c, o_sat and o_valid SHALL hold stable.
REQ-020 The difference SHALL be computed as sext(i_a) - sext(i_b) in N+1 bits, so it never overflows.
REQ-021 Clamping: a difference > 2^(N-1)-1 SHALL give o_c = 2^(N-1)-1 with o_sat=1.
REQ-022 Clamping: a difference < -2^(N-1) SHALL give o_c = -2^(N-1) with o_sat=1.
REQ-023 Otherwise o_c SHALL equal the difference with o_sat=0; a result exactly at a limit is not saturation.
REQ-024 o_sat_cnt SHALL increment by 1 on each output handshake with o_sat=1, and SHALL stick at 2^CNT_W-1 without wrapping.
REQ-025 i_clr_cnt=1 SHALL clear o_sat_cnt to 0; if it coincides with a counted handshake, o_sat_cnt SHALL become 1.
REQ-026 With no stall, S1 and S2 SHALL hold data in order; no pair SHALL be dropped or duplicated under any i_valid/i_ready pattern.

Reset
REQ-027 While i_rst=1, S1 and S2 SHALL be marked empty and o_valid, o_c, o_sat and o_sat_cnt SHALL be 0.
REQ-028 While i_rst=1, o_ready SHALL be 0; o_ready SHALL be 1 in the first cycle after i_rst deasserts.
REQ-029 A reset asserted mid-stream SHALL discard all in-flight pairs, with no later output for them.

Verification
REQ-030 N=7, i_ready=1, pairs (10,3), (50,-30), (-50,30), (-64,0), (0,-64) back-to-back -> o_c 7, 63, -64, -64, 63 two cycles after each acceptance; o_sat 0,1,1,0,1; o_sat_cnt ends at 3.
REQ-031 Stream 4 pairs with i_ready=0 -> two pairs accepted, then o_ready=0, o_c held constant; raise i_ready -> all 4 results emerge in order, none lost.
REQ-032 Toggle i_ready 1/0 each cycle with i_valid=1 for 20 random pairs -> output sequence matches a reference model of sat(a-b), count equal to saturated outputs.
REQ-033 CNT_W=2, five saturating pairs -> o_sat_cnt 1,2,3,3,3; then i_clr_cnt coincident with a saturating handshake -> o_sat_cnt=1.
REQ-034 Assert i_rst for one cycle with both stages full -> o_valid=0 next cycle, o_sat_cnt=0, no stale result ever emerges.

Source files
------------

// File: rtl/sub_saturate_pipe_if.sv
`default_nettype none
// ============================================================================
//  Module      : sub_saturate_pipe_if
//  Description : Handshake and data bundle for sub_saturate_pipe.
//                Carries the operand pair with its valid/ready handshake, the
//                result with its valid/ready handshake, the saturation
//                counter clear and the saturation counter value.
//  Parameters  : N      - signed operand/result width
//                CNT_W  - saturation counter width
//  Modports    : master - upstream producer + downstream consumer side
//                slave  - the subtract/saturate pipeline itself
//  Revision    : 1.0  initial release
// ============================================================================
interface sub_saturate_pipe_if #(
    parameter int N     = 7,
    parameter int CNT_W = 16
);
    // Operand side
    logic                i_valid;
    logic                o_ready;
    logic signed [N-1:0] i_a;
    logic signed [N-1:0] i_b;

    // Result side
    logic                o_valid;
    logic                i_ready;
    logic signed [N-1:0] o_c;
    logic                o_sat;

    // Saturation statistics
    logic                i_clr_cnt;
    logic [CNT_W-1:0]    o_sat_cnt;

    modport master (
        output i_valid,
        input  o_ready,
        output i_a,
        output i_b,
        input  o_valid,
        output i_ready,
        input  o_c,
        input  o_sat,
        output i_clr_cnt,
        input  o_sat_cnt
    );

    modport slave (
        input  i_valid,
        output o_ready,
        input  i_a,
        input  i_b,
        output o_valid,
        input  i_ready,
        output o_c,
        output o_sat,
        input  i_clr_cnt,
        output o_sat_cnt
    );
endinterface
`default_nettype wire

// File: rtl/sub_saturate_pipe.sv
`default_nettype none
// ============================================================================
//  Module      : sub_saturate_pipe
//  Description : Two-stage pipelined saturating subtractor c = sat(a - b)
//                with valid/ready flow control on both sides and a sticky
//                count of saturated results delivered downstream.
//                  S1 : full-precision (N+1 bit) difference
//                  S2 : clamped N-bit result and saturation flag
//  Ports       : i_clk       - clock, rising edge
//                i_rst       - synchronous active-high reset
//                bus.i_valid / bus.o_ready / bus.i_a / bus.i_b
//                            - operand pair and its handshake
//                bus.o_valid / bus.i_ready / bus.o_c / bus.o_sat
//                            - result, clamp flag and its handshake
//                bus.i_clr_cnt / bus.o_sat_cnt
//                            - clear and value of the saturation counter
//  Revision    : 1.0  initial release
// ============================================================================
module sub_saturate_pipe #(
    parameter int N     = 7,
    parameter int CNT_W = 16
) (
    input  wire logic          i_clk,
    input  wire logic          i_rst,
    sub_saturate_pipe_if.slave bus
);

    // ------------------------------------------------------------------------
    // Constants
    // ------------------------------------------------------------------------
    localparam logic signed [N-1:0] C_MAX     = {1'b0, {(N-1){1'b1}}};
    localparam logic signed [N-1:0] C_MIN     = {1'b1, {(N-1){1'b0}}};
    localparam logic [CNT_W-1:0]    C_CNT_MAX = {CNT_W{1'b1}};

    // ------------------------------------------------------------------------
    // Pipeline state
    // ------------------------------------------------------------------------
    logic                r_s1_valid;
    logic signed [N:0]   r_s1_diff;

    logic                r_s2_valid;
    logic signed [N-1:0] r_s2_c;
    logic                r_s2_sat;

    logic [CNT_W-1:0]    r_sat_cnt;

    // ------------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------------
    logic w_s2_load;
    logic w_s1_adv;
    logic w_in_hs;
    logic w_sat_hs;

    // S2 can take a new value when it is empty or its value leaves this cycle.
    assign w_s2_load = !r_s2_valid || bus.i_ready;

    // S1 can take a new pair when it is empty or its content moves into S2.
    // This is a pure function of register state and i_ready, so a stalled
    // pipe back-pressures in the same cycle without a skid buffer.
    assign w_s1_adv  = !r_s1_valid || w_s2_load;

    // Hold off upstream during reset so nothing is accepted and then lost.
    assign bus.o_ready = w_s1_adv && !i_rst;

    assign w_in_hs   = bus.i_valid && w_s1_adv;

    // A delivered result that was clamped.
    assign w_sat_hs  = r_s2_valid && bus.i_ready && r_s2_sat;

    // ------------------------------------------------------------------------
    // S1 input: exact difference in N+1 bits. Both operands are sign-extended
    // by one bit so the subtraction can never wrap.
    // ------------------------------------------------------------------------
    logic signed [N:0] w_a_ext;
    logic signed [N:0] w_b_ext;
    logic signed [N:0] w_diff;

    assign w_a_ext = {bus.i_a[N-1], bus.i_a};
    assign w_b_ext = {bus.i_b[N-1], bus.i_b};
    assign w_diff  = w_a_ext - w_b_ext;

    // ------------------------------------------------------------------------
    // S2 input: clamp the N+1 bit difference to N bits.
    // The difference fits in N bits exactly when its two top bits agree;
    // when they differ, the top bit tells which rail was crossed.
    // ------------------------------------------------------------------------
    logic                w_pos_ovf;
    logic                w_neg_ovf;
    logic signed [N-1:0] w_clamp_c;
    logic                w_clamp_sat;

    always_comb begin
        w_pos_ovf   = !r_s1_diff[N] &&  r_s1_diff[N-1];
        w_neg_ovf   =  r_s1_diff[N] && !r_s1_diff[N-1];
        w_clamp_c   = r_s1_diff[N-1:0];
        w_clamp_sat = 1'b0;
        if (w_pos_ovf) begin
            w_clamp_c   = C_MAX;
            w_clamp_sat = 1'b1;
        end else if (w_neg_ovf) begin
            w_clamp_c   = C_MIN;
            w_clamp_sat = 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Stage 1 register
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_diff  <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= bus.i_valid;
            // Only capture real operands; an empty slot keeps the old value
            // to avoid needless toggling.
            if (w_in_hs) begin
                r_s1_diff <= w_diff;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Stage 2 register (output stage). Holding while stalled keeps
    // o_c/o_sat/o_valid stable until the consumer takes them.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_s2_valid <= 1'b0;
            r_s2_c     <= '0;
            r_s2_sat   <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_c   <= w_clamp_c;
                r_s2_sat <= w_clamp_sat;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Saturation event counter. Clear wins over the old value but not over a
    // coincident event, which is counted on top of the cleared value.
    // Sticks at all-ones instead of wrapping.
    // ------------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sat_cnt <= '0;
        end else if (bus.i_clr_cnt) begin
            r_sat_cnt <= CNT_W'(w_sat_hs);
        end else if (w_sat_hs && (r_sat_cnt != C_CNT_MAX)) begin
            r_sat_cnt <= r_sat_cnt + 1'b1;
        end
    end

    // ------------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------------
    assign bus.o_valid   = r_s2_valid;
    assign bus.o_c       = r_s2_c;
    assign bus.o_sat     = r_s2_sat;
    assign bus.o_sat_cnt = r_sat_cnt;

endmodule
`default_nettype wire
